operand_stack: RTL

Parametrised operand stack for the WebAssembly CPU core, generalising the fixed 64-bit result/empty path into a configurable-width, configurable-depth stack with push, pop, unary/binary replace and dup operations. It sits between the decode/execute stage and the `result`/`result_empty`/`trap` outputs of `cpu`. It exposes the top two entries combinationally from registers so that the ALU can consume operands without a read cycle. It also reports stack faults using the CPU's 4-bit trap encoding.

---
 rtl/operand_stack.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/operand_stack.sv
// -----------------------------------------------------------------------------
// operand_stack
//
// Parametrised operand stack for the WebAssembly CPU core. It supports push,
// pop, unary/binary replace and dup operations. The top two entries are held
// in dedicated registers, so the ALU sees its operands combinationally with no
// read cycle. Deeper entries are kept in a register array.
//
// Optional feature macro: OPERAND_STACK_TRAP_EN
//   defined   : stack faults latch a sticky trap code, and op_ready drops
//               until reset.
//   undefined : trap is tied to 0 and op_ready is tied to 1. Faulting ops
//               are silently discarded, and illegal opcodes act as NOP.
//
// Parameters
//   WIDTH  bits per entry
//   DEPTH  maximum number of entries (>= 2)
//   CW     width of count, derived as $clog2(DEPTH+1)
//
// Ports
//   clk           clock; all state changes on the rising edge
//   reset         asynchronous, active-low reset
//   op_valid      operation request
//   op_ready      stack accepts an operation (depends only on registered trap)
//   op            0 NOP, 1 PUSH, 2 DROP, 3 UNARY, 4 BINARY, 5 DUP, 6-7 illegal
//   op_data       PUSH value, or UNARY/BINARY result
//   top           entry 0, or 0 when empty
//   next          entry 1, or 0 when count < 2
//   count         number of valid entries
//   result        alias of top
//   result_empty  count == 0
//   full          count == DEPTH
//   trap          0 none, 1 overflow, 2 underflow, 3 illegal op (sticky)
// -----------------------------------------------------------------------------
module operand_stack #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_data,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] next,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] result,
  output logic             result_empty,
  output logic             full,
  output logic [3:0]       trap
);

  // Entries 2..DEPTH-1 live in the array. Entry k sits at index count-1-k, so
  // entry 2 is at count-3. As a result, BINARY and DROP never move array
  // contents; only the boundary slot is read or written.
  localparam int MEM_N = (DEPTH > 2) ? DEPTH - 2 : 1;
  localparam int IW    = (MEM_N > 1) ? $clog2(MEM_N) : 1;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_PUSH   = 3'd1;
  localparam logic [2:0] OP_DROP   = 3'd2;
  localparam logic [2:0] OP_UNARY  = 3'd3;
  localparam logic [2:0] OP_BINARY = 3'd4;
  localparam logic [2:0] OP_DUP    = 3'd5;

  localparam logic [3:0] TRAP_NONE = 4'd0;
  localparam logic [3:0] TRAP_OVF  = 4'd1;
  localparam logic [3:0] TRAP_UNF  = 4'd2;
  localparam logic [3:0] TRAP_ILL  = 4'd3;

  logic [WIDTH-1:0] top_q, top_d;
  logic [WIDTH-1:0] next_q, next_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [MEM_N];

  logic             has1, has2, has3, not_full;
  logic [3:0]       fault_code;
  logic             fire;
  logic             wr_en;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;
  logic [WIDTH-1:0] rd_val;

  // Fault decode. Illegal opcodes take priority over underflow, and underflow
  // takes priority over overflow.
  always_comb begin
    has1       = (count_q != '0);
    has2       = (count_q >= CW'(2));
    has3       = (count_q >= CW'(3));
    not_full   = (count_q != CW'(DEPTH));
    fault_code = TRAP_NONE;
    case (op)
      OP_NOP:    fault_code = TRAP_NONE;
      OP_PUSH:   if (!not_full) fault_code = TRAP_OVF;
      OP_DROP:   if (!has1)     fault_code = TRAP_UNF;
      OP_UNARY:  if (!has1)     fault_code = TRAP_UNF;
      OP_BINARY: if (!has2)     fault_code = TRAP_UNF;
      OP_DUP: begin
        if (!has1)          fault_code = TRAP_UNF;
        else if (!not_full) fault_code = TRAP_OVF;
      end
      default:   fault_code = TRAP_ILL;
    endcase
  end

  assign fire   = op_valid && op_ready && (fault_code == TRAP_NONE);
  assign wr_idx = IW'(count_q - CW'(2));
  assign rd_idx = IW'(count_q - CW'(3));
  // rd_idx may be out of range while count < 3. The value is only used when
  // has3 is set.
  assign rd_val = mem_q[rd_idx];

  always_comb begin
    top_d   = top_q;
    next_d  = next_q;
    count_d = count_q;
    wr_en   = 1'b0;
    if (fire) begin
      case (op)
        OP_PUSH: begin
          top_d   = op_data;
          next_d  = top_q;
          count_d = count_q + CW'(1);
          wr_en   = has2;
        end
        OP_DROP: begin
          top_d   = next_q;
          next_d  = has3 ? rd_val : '0;
          count_d = count_q - CW'(1);
        end
        OP_UNARY: begin
          top_d = op_data;
        end
        OP_BINARY: begin
          top_d   = op_data;
          next_d  = has3 ? rd_val : '0;
          count_d = count_q - CW'(1);
        end
        OP_DUP: begin
          next_d  = top_q;
          count_d = count_q + CW'(1);
          wr_en   = has2;
        end
        default: begin
          top_d = top_q;
        end
      endcase
    end
  end

  // The top and next registers are kept at zero whenever they are logically
  // invalid. This lets the outputs come straight from the flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      top_q   <= '0;
      next_q  <= '0;
      count_q <= '0;
    end else begin
      top_q   <= top_d;
      next_q  <= next_d;
      count_q <= count_d;
    end
  end

  // Deep storage has no reset. Slots are written before they are ever read,
  // and popped slots are left stale.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= next_q;
    end
  end

`ifdef OPERAND_STACK_TRAP_EN
  logic [3:0] trap_q, trap_d;

  always_comb begin
    trap_d = trap_q;
    if (op_valid && op_ready && (fault_code != TRAP_NONE)) begin
      trap_d = fault_code;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trap_q <= TRAP_NONE;
    end else begin
      trap_q <= trap_d;
    end
  end

  assign trap     = trap_q;
  assign op_ready = (trap_q == TRAP_NONE);
`else
  assign trap     = TRAP_NONE;
  assign op_ready = 1'b1;
`endif

  assign top          = top_q;
  assign next         = next_q;
  assign count        = count_q;
  assign result       = top_q;
  assign result_empty = (count_q == '0);
  assign full         = (count_q == CW'(DEPTH));

endmodule
